// File: rtl/arm_pkg.sv
// Shared ARM datapath constants and types used by the register file and its bench.
package arm_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 16;
  localparam int PC_IDX         = DEF_NUM_REGS - 1;
  localparam int DEF_PC_OFFSET  = 8;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter tracking loads in flight; full gates further issues.
module sb_counter #(
  parameter  int MAX = 4,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);

  // Count up or down; an inc and dec in the same cycle cancel out, and both ends saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Full is derived from the registered count, so it rises the cycle after the last increment.
  always_comb begin
    full = (count == CW'(MAX));
  end

endmodule

// File: rtl/reg_file_sb.sv
// ARM register file with PC read port, write-through bypass and a load scoreboard.
module reg_file_sb
  import arm_pkg::*;
#(
  parameter  int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter  int NUM_REGS        = DEF_NUM_REGS,
  parameter  int NUM_READ        = 3,
  parameter  int PC_OFFSET       = DEF_PC_OFFSET,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int AW              = $clog2(NUM_REGS),
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_READ-1:0][AW-1:0]         ra,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]               pc_in,
  input  logic                                we,
  input  logic [AW-1:0]                       wa,
  input  logic [DATA_WIDTH-1:0]               wd,
  input  logic                                wb_clear,
  input  logic                                ld_issue,
  input  logic [AW-1:0]                       ld_dst,
  output logic                                ld_ready,
  output logic [NUM_READ-1:0]                 hazard,
  output logic [CW-1:0]                       outstanding,
  output logic                                pc_wr_err
);

  localparam logic [AW-1:0] PC = AW'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  issue_ok;
  logic                  clr_any;
  logic                  clr_ok;
  logic                  full;

  // Qualify scoreboard events: issues need a free slot and a non-PC target,
  // and only a clear of a register that is actually busy retires a load.
  always_comb begin
    issue_ok = ld_issue && ld_ready && (ld_dst != PC);
    clr_any  = we && wb_clear;
    clr_ok   = clr_any && busy[wa];
    ld_ready = !full;
  end

  sb_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_sb_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (issue_ok),
    .dec   (clr_ok),
    .count (outstanding),
    .full  (full)
  );

  // Register array write; writes aimed at the PC are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wa != PC)) begin
      regs[wa] <= wd;
    end
  end

  // Busy bits; the set is applied after the clear so a same-register set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (clr_ok)   busy[wa]     <= 1'b0;
      if (issue_ok) busy[ld_dst] <= 1'b1;
    end
  end

  // One-cycle error pulse flagging an attempted PC write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_wr_err <= 1'b0;
    else        pc_wr_err <= we && (wa == PC);
  end

  // Read muxes: PC first, then same-cycle write bypass, then the array; hazard
  // reports a busy source unless this cycle's writeback is clearing it.
  always_comb begin
    rd     = '0;
    hazard = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (ra[i] == PC) begin
        rd[i] = pc_in + DATA_WIDTH'(PC_OFFSET);
      end else if (we && (wa == ra[i])) begin
        rd[i] = wd;
      end else begin
        rd[i] = regs[ra[i]];
      end
      hazard[i] = (ra[i] != PC) && busy[ra[i]] && !(clr_any && (wa == ra[i]));
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb.
module tb_reg_file_sb;
  import arm_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [2:0][3:0]       ra;
  logic [2:0][31:0]      rd;
  logic [31:0]           pc_in;
  logic                  we;
  logic [3:0]            wa;
  logic [31:0]           wd;
  logic                  wb_clear;
  logic                  ld_issue;
  logic [3:0]            ld_dst;
  logic                  ld_ready;
  logic [2:0]            hazard;
  logic [2:0]            outstanding;
  logic                  pc_wr_err;

  int tests_run;
  int tests_failed;

  reg_file_sb dut (
    .clk         (clk),
    .reset       (reset),
    .ra          (ra),
    .rd          (rd),
    .pc_in       (pc_in),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .wb_clear    (wb_clear),
    .ld_issue    (ld_issue),
    .ld_dst      (ld_dst),
    .ld_ready    (ld_ready),
    .hazard      (hazard),
    .outstanding (outstanding),
    .pc_wr_err   (pc_wr_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a write port request; inputs settle before the next check.
  task automatic apply_write(input logic [3:0] a, input logic [31:0] d, input logic clr);
    we       = 1'b1;
    wa       = a;
    wd       = d;
    wb_clear = clr;
    #1;
  endtask

  task automatic idle_write();
    we       = 1'b0;
    wb_clear = 1'b0;
    #1;
  endtask

  // Issue one load and let it land at the next edge.
  task automatic issue_load(input logic [3:0] dst);
    ld_issue = 1'b1;
    ld_dst   = dst;
    tick();
    ld_issue = 1'b0;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    ra       = '0;
    pc_in    = '0;
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    wb_clear = 1'b0;
    ld_issue = 1'b0;
    ld_dst   = '0;
    ra[0] = 4'd0; ra[1] = 4'd1; ra[2] = 4'd2;
    #12;
    check_output("reset_outstanding", 32'(outstanding), 32'd0);
    check_output("reset_ld_ready", 32'(ld_ready), 32'd1);
    check_output("reset_pc_wr_err", 32'(pc_wr_err), 32'd0);
    check_output("reset_rd1", rd[1], 32'd0);
    check_output("reset_hazard", 32'(hazard), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Load writebacks into r1 and r11, then a store-style read of both.
    apply_write(4'd1, 32'd15, 1'b1);
    tick();
    apply_write(4'd11, 32'd32, 1'b1);
    tick();
    idle_write();
    ra[0] = 4'd11; ra[1] = 4'd1; ra[2] = 4'd0;
    #1;
    check_output("str_rd0_r11", rd[0], 32'd32);
    check_output("str_rd1_r1", rd[1], 32'd15);
    check_output("str_hazard", 32'(hazard), 32'd0);
    check_output("wb_nonbusy_no_dec", 32'(outstanding), 32'd0);

    // PC read returns pc_in+8; writes to the PC are dropped and flagged.
    ra[0] = PC_IDX[3:0]; pc_in = 32'h100;
    #1;
    check_output("pc_read", rd[0], 32'h108);
    apply_write(PC_IDX[3:0], 32'd5, 1'b0);
    check_output("pc_read_during_write", rd[0], 32'h108);
    check_output("pc_wr_err_pre", 32'(pc_wr_err), 32'd0);
    tick();
    idle_write();
    check_output("pc_wr_err_pulse", 32'(pc_wr_err), 32'd1);
    check_output("pc_write_r1_kept", rd[1], 32'd15);
    check_output("pc_write_r0_kept", rd[2], 32'd0);
    tick();
    check_output("pc_wr_err_drop", 32'(pc_wr_err), 32'd0);
    check_output("pc_read_after", rd[0], 32'h108);

    // Same-cycle bypass, then the value held in the array.
    ra[1] = 4'd3;
    apply_write(4'd3, 32'hDEADBEEF, 1'b0);
    check_output("bypass_rd1", rd[1], 32'hDEADBEEF);
    tick();
    idle_write();
    check_output("stored_rd1", rd[1], 32'hDEADBEEF);

    // Load to r2 raises a hazard until its writeback clears it.
    ra[0] = 4'd2;
    issue_load(4'd2);
    check_output("ld_r2_outstanding", 32'(outstanding), 32'd1);
    check_output("ld_r2_hazard", 32'(hazard), 32'b001);
    apply_write(4'd2, 32'd77, 1'b1);
    check_output("wb_r2_hazard_same_cycle", 32'(hazard), 32'b000);
    check_output("wb_r2_bypass", rd[0], 32'd77);
    tick();
    idle_write();
    check_output("wb_r2_outstanding", 32'(outstanding), 32'd0);

    // Fill the scoreboard, then a fifth issue must be ignored.
    for (int i = 4; i < 8; i++) begin
      check_output("fill_ld_ready", 32'(ld_ready), 32'd1);
      issue_load(4'(i));
    end
    check_output("full_outstanding", 32'(outstanding), 32'd4);
    check_output("full_ld_ready", 32'(ld_ready), 32'd0);
    issue_load(4'd8);
    ra[0] = 4'd8; ra[1] = 4'd7; ra[2] = 4'd4;
    #1;
    check_output("fifth_ignored_outstanding", 32'(outstanding), 32'd4);
    check_output("fifth_ignored_hazard", 32'(hazard), 32'b110);

    // Drain: clear r4, then a clear of non-busy r8 must not decrement.
    apply_write(4'd4, 32'd44, 1'b1);
    tick();
    apply_write(4'd8, 32'd88, 1'b1);
    tick();
    idle_write();
    check_output("clear_nonbusy_outstanding", 32'(outstanding), 32'd3);
    for (int i = 5; i < 8; i++) begin
      apply_write(4'(i), 32'(i), 1'b1);
      tick();
    end
    idle_write();
    check_output("drained_outstanding", 32'(outstanding), 32'd0);

    // Load to the PC is ignored.
    issue_load(PC_IDX[3:0]);
    check_output("pc_load_ignored", 32'(outstanding), 32'd0);

    // Set and clear of the same register in one cycle: the new load stays pending.
    ra[0] = 4'd5;
    issue_load(4'd5);
    ld_issue = 1'b1; ld_dst = 4'd5;
    apply_write(4'd5, 32'd55, 1'b1);
    check_output("setclr_hazard_same_cycle", 32'(hazard[0]), 32'd0);
    tick();
    ld_issue = 1'b0;
    idle_write();
    check_output("setclr_outstanding", 32'(outstanding), 32'd1);
    check_output("setclr_hazard_after", 32'(hazard[0]), 32'd1);
    apply_write(4'd5, 32'd56, 1'b1);
    tick();
    idle_write();
    check_output("setclr_drain", 32'(outstanding), 32'd0);

    // Mid-cycle reset discards the in-flight load to r9 and clears the array.
    ra[0] = 4'd9; ra[1] = 4'd1;
    issue_load(4'd9);
    check_output("r9_outstanding", 32'(outstanding), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_output("midreset_outstanding", 32'(outstanding), 32'd0);
    check_output("midreset_hazard", 32'(hazard), 32'd0);
    check_output("midreset_r1", rd[1], 32'd0);
    check_output("midreset_ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    apply_write(4'd9, 32'd99, 1'b1);
    tick();
    idle_write();
    check_output("stale_wb_r9", 32'(outstanding), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
